people_top_control: RTL and testbench



---
 rtl/people_pkg.sv | 16 +
 rtl/people_glide_timer.sv | 32 +++
 rtl/people_top_control.sv | 109 ++++++++++
 tb/tb_people_top_control.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/people_pkg.sv
// people_pkg: shared play-stage constants, direction/state encodings and bound check for the player controller.
package people_pkg;
  localparam logic [2:0] PLAY = 3'd5;
  localparam logic [9:0] MIN_UP = 10'd65;
  localparam logic [9:0] MAX_UP = 10'd395;
  localparam logic [9:0] MIN_LEFT = 10'd160;
  localparam logic [9:0] MAX_LEFT = 10'd460;
  localparam logic [9:0] GOAL_UP = 10'd65;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;
  typedef enum logic [2:0] {ST_IDLE, ST_READY, ST_MOVING, ST_DEAD, ST_GOAL} state_e;
  function automatic logic fits(input logic [9:0] up, input logic [9:0] left, input logic [9:0] step, input dir_e d);
    return d == DIR_UP   ? up >= MIN_UP + step :
           d == DIR_DOWN ? up + step <= MAX_UP :
           d == DIR_LEFT ? left >= MIN_LEFT + step : left + step <= MAX_LEFT;
  endfunction
endpackage

// File: rtl/people_glide_timer.sv
// people_glide_timer: tick divider plus remaining-step counter; i_start arms a glide, o_step pulses per pixel, o_done on the last one.
module people_glide_timer #(
  parameter int TICK_DIV = 4,
  parameter logic [9:0] STEP = 10'd20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_run,
  output logic o_step,
  output logic o_done
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [TW-1:0] r_tick;
  logic [9:0] r_rem;
  assign o_step = i_run && r_tick == TW'(TICK_DIV - 1);
  assign o_done = o_step && r_rem == 10'd1;
  always_ff @(posedge clk) begin
    if (!rst || (!i_run && !i_start)) begin
      r_tick <= '0;
      r_rem <= '0;
    end else if (i_start) begin
      r_tick <= '0;
      r_rem <= STEP;
    end else if (o_step) begin
      r_tick <= '0;
      r_rem <= r_rem - 10'd1;
    end else begin
      r_tick <= r_tick + TW'(1);
    end
  end
endmodule

// File: rtl/people_top_control.sv
// people_top_control: player sprite glide/death/goal controller for the play stage.
// Optional macro LIVES_EN enables a 3-life counter with respawn; otherwise the first hit edge is fatal.
module people_top_control
  import people_pkg::*;
#(
  parameter logic [9:0] SPAWN_UP = 10'd335,
  parameter logic [9:0] SPAWN_LEFT = 10'd200,
  parameter logic [9:0] STEP = 10'd20,
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] stage_state,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       hit,
  output logic [9:0] people_up,
  output logic [9:0] people_left,
  output logic       moving,
  output logic       dead,
  output logic       goal,
  output logic [1:0] lives
);
  state_e r_state, w_next;
  dir_e r_dir, w_key_dir;
  logic r_hit_q;
  logic [9:0] r_up, r_left, w_up_nx, w_left_nx, w_up_step, w_left_step;
  logic w_play, w_hit_rise, w_active, w_start, w_step, w_done;
`ifdef LIVES_EN
  logic [1:0] r_lives, w_lives_nx;
  assign lives = r_lives;
`else
  assign lives = 2'd1;
`endif
  assign w_play = stage_state == PLAY;
  assign w_hit_rise = hit && !r_hit_q;
  assign w_active = r_state == ST_READY || r_state == ST_MOVING;
  assign w_key_dir = key_up ? DIR_UP : key_down ? DIR_DOWN : key_left ? DIR_LEFT : DIR_RIGHT;
  assign w_start = w_play && r_state == ST_READY && !w_hit_rise &&
                   (key_up || key_down || key_left || key_right) && fits(r_up, r_left, STEP, w_key_dir);
  assign w_up_step = r_dir == DIR_UP ? r_up - 10'd1 : r_dir == DIR_DOWN ? r_up + 10'd1 : r_up;
  assign w_left_step = r_dir == DIR_LEFT ? r_left - 10'd1 : r_dir == DIR_RIGHT ? r_left + 10'd1 : r_left;
  people_glide_timer #(.TICK_DIV(TICK_DIV), .STEP(STEP)) u_timer (
    .clk(clk), .rst(rst), .i_start(w_start), .i_run(r_state == ST_MOVING),
    .o_step(w_step), .o_done(w_done)
  );
  // A hit edge outranks both keys and a completing glide.
  always_comb begin
    w_next = r_state;
    w_up_nx = r_up;
    w_left_nx = r_left;
`ifdef LIVES_EN
    w_lives_nx = r_lives;
`endif
    if (!w_play) begin
      w_next = ST_IDLE;
      w_up_nx = SPAWN_UP;
      w_left_nx = SPAWN_LEFT;
`ifdef LIVES_EN
      w_lives_nx = 2'd3;
`endif
    end else if (r_state == ST_IDLE) begin
      w_next = ST_READY;
    end else if (w_active && w_hit_rise) begin
`ifdef LIVES_EN
      w_lives_nx = r_lives - 2'd1;
      w_next = r_lives == 2'd1 ? ST_DEAD : ST_READY;
      w_up_nx = r_lives == 2'd1 ? r_up : SPAWN_UP;
      w_left_nx = r_lives == 2'd1 ? r_left : SPAWN_LEFT;
`else
      w_next = ST_DEAD;
`endif
    end else if (w_start) begin
      w_next = ST_MOVING;
    end else if (w_step) begin
      w_up_nx = w_up_step;
      w_left_nx = w_left_step;
      w_next = !w_done ? ST_MOVING : w_up_step <= GOAL_UP ? ST_GOAL : ST_READY;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_up <= SPAWN_UP;
      r_left <= SPAWN_LEFT;
      r_dir <= DIR_UP;
      r_hit_q <= 1'b0;
    end else begin
      r_state <= w_next;
      r_up <= w_up_nx;
      r_left <= w_left_nx;
      r_hit_q <= hit;
      if (w_start) r_dir <= w_key_dir;
    end
  end
`ifdef LIVES_EN
  always_ff @(posedge clk) begin
    if (!rst) r_lives <= 2'd3;
    else r_lives <= w_lives_nx;
  end
`endif
  assign people_up = r_up;
  assign people_left = r_left;
  assign moving = r_state == ST_MOVING;
  assign dead = r_state == ST_DEAD;
  assign goal = r_state == ST_GOAL;
endmodule

// File: tb/tb_people_top_control.sv
// tb_people_top_control: directed bench; u1 uses default spawn, u2 spawns at row 345 so the goal row is reachable.
module tb_people_top_control;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] stage_state = 3'd0;
  logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0, hit = 1'b0;
  logic [9:0] up1, left1, up2, left2;
  logic mv1, dead1, goal1, mv2, dead2, goal2;
  logic [1:0] lives1, lives2;
  int checks = 0;
  int errors = 0;
`ifdef LIVES_EN
  localparam logic [1:0] LIVES0 = 2'd3;
`else
  localparam logic [1:0] LIVES0 = 2'd1;
`endif
  people_top_control u1 (
    .clk(clk), .rst(rst), .stage_state(stage_state), .key_up(key_up), .key_down(key_down),
    .key_left(key_left), .key_right(key_right), .hit(hit), .people_up(up1), .people_left(left1),
    .moving(mv1), .dead(dead1), .goal(goal1), .lives(lives1)
  );
  people_top_control #(.SPAWN_UP(10'd345)) u2 (
    .clk(clk), .rst(rst), .stage_state(stage_state), .key_up(key_up), .key_down(key_down),
    .key_left(key_left), .key_right(key_right), .hit(hit), .people_up(up2), .people_left(left2),
    .moving(mv2), .dead(dead2), .goal(goal2), .lives(lives2)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic press(input logic [3:0] k);
    {key_up, key_down, key_left, key_right} = k;
    tick(1);
    {key_up, key_down, key_left, key_right} = 4'b0;
  endtask
  task automatic enter_play();
    stage_state = 3'd0;
    tick(1);
    stage_state = 3'd5;
    tick(1);
  endtask
  task automatic test_reset();
    rst = 1'b0;
    tick(2);
    checks++; if (up1 !== 10'd335 || left1 !== 10'd200) begin errors++; $display("FAIL reset_pos: got %0d,%0d expected 335,200", up1, left1); end
    checks++; if ({mv1, dead1, goal1} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {mv1, dead1, goal1}); end
    checks++; if (lives1 !== LIVES0) begin errors++; $display("FAIL reset_lives: got %0d expected %0d", lives1, LIVES0); end
    checks++; if (up2 !== 10'd345) begin errors++; $display("FAIL reset_spawn2: got %0d expected 345", up2); end
    rst = 1'b1;
  endtask
  task automatic test_glide();
    stage_state = 3'd5;
    tick(1);
    press(4'b1000);
    checks++; if (mv1 !== 1'b1 || up1 !== 10'd335) begin errors++; $display("FAIL glide_start: got mv=%b up=%0d expected mv=1 up=335", mv1, up1); end
    tick(3);
    checks++; if (up1 !== 10'd335) begin errors++; $display("FAIL glide_tick3: got %0d expected 335", up1); end
    tick(1);
    checks++; if (up1 !== 10'd334) begin errors++; $display("FAIL glide_tick4: got %0d expected 334", up1); end
    tick(75);
    checks++; if (up1 !== 10'd316 || mv1 !== 1'b1) begin errors++; $display("FAIL glide_79: got up=%0d mv=%b expected up=316 mv=1", up1, mv1); end
    tick(1);
    checks++; if (up1 !== 10'd315 || mv1 !== 1'b0) begin errors++; $display("FAIL glide_end: got up=%0d mv=%b expected up=315 mv=0", up1, mv1); end
    checks++; if (up2 !== 10'd325) begin errors++; $display("FAIL glide_u2: got %0d expected 325", up2); end
  endtask
  task automatic test_bounds();
    for (int i = 0; i < 13; i++) begin
      press(4'b0001);
      tick(80);
    end
    checks++; if (left1 !== 10'd460) begin errors++; $display("FAIL bounds_reach: got %0d expected 460", left1); end
    press(4'b0001);
    checks++; if (mv1 !== 1'b0 || left1 !== 10'd460) begin errors++; $display("FAIL bounds_right_ignored: got mv=%b left=%0d expected mv=0 left=460", mv1, left1); end
    press(4'b1010);
    checks++; if (mv1 !== 1'b1) begin errors++; $display("FAIL priority_start: got mv=%b expected 1", mv1); end
    tick(80);
    checks++; if (up1 !== 10'd295 || left1 !== 10'd460) begin errors++; $display("FAIL priority_up: got %0d,%0d expected 295,460", up1, left1); end
    press(4'b1000);
    tick(5);
    press(4'b0010);
    tick(74);
    checks++; if (up1 !== 10'd275 || left1 !== 10'd460 || mv1 !== 1'b0) begin errors++; $display("FAIL no_queue: got %0d,%0d mv=%b expected 275,460 mv=0", up1, left1, mv1); end
  endtask
  task automatic climb_to_85();
    enter_play();
    for (int i = 0; i < 13; i++) begin
      press(4'b1000);
      tick(80);
    end
  endtask
  task automatic test_goal();
    climb_to_85();
    checks++; if (up2 !== 10'd85 || goal2 !== 1'b0) begin errors++; $display("FAIL goal_pre: got up=%0d goal=%b expected 85,0", up2, goal2); end
    press(4'b1000);
    tick(79);
    checks++; if (up2 !== 10'd66 || goal2 !== 1'b0) begin errors++; $display("FAIL goal_79: got up=%0d goal=%b expected 66,0", up2, goal2); end
    tick(1);
    checks++; if (up2 !== 10'd65 || goal2 !== 1'b1 || mv2 !== 1'b0) begin errors++; $display("FAIL goal_set: got up=%0d goal=%b mv=%b expected 65,1,0", up2, goal2, mv2); end
    checks++; if (up1 !== 10'd75 || goal1 !== 1'b0) begin errors++; $display("FAIL goal_u1_none: got up=%0d goal=%b expected 75,0", up1, goal1); end
    press(4'b0100);
    tick(8);
    checks++; if (up2 !== 10'd65 || mv2 !== 1'b0 || goal2 !== 1'b1) begin errors++; $display("FAIL goal_sticky: got up=%0d mv=%b goal=%b expected 65,0,1", up2, mv2, goal2); end
  endtask
  task automatic test_hit();
    enter_play();
    press(4'b1000);
    tick(11);
    hit = 1'b1;
    tick(1);
`ifdef LIVES_EN
    checks++; if (dead1 !== 1'b0 || up1 !== 10'd335 || lives1 !== 2'd2 || mv1 !== 1'b0) begin errors++; $display("FAIL hit_respawn: got dead=%b up=%0d lives=%0d mv=%b expected 0,335,2,0", dead1, up1, lives1, mv1); end
`else
    checks++; if (dead1 !== 1'b1 || up1 !== 10'd333 || mv1 !== 1'b0) begin errors++; $display("FAIL hit_dead: got dead=%b up=%0d mv=%b expected 1,333,0", dead1, up1, mv1); end
    tick(8);
    checks++; if (up1 !== 10'd333 || dead1 !== 1'b1) begin errors++; $display("FAIL hit_frozen: got up=%0d dead=%b expected 333,1", up1, dead1); end
`endif
    hit = 1'b0;
    climb_to_85();
    press(4'b1000);
    tick(78);
    hit = 1'b1;
    tick(1);
`ifdef LIVES_EN
    checks++; if (goal2 !== 1'b0 || dead2 !== 1'b0 || up2 !== 10'd345 || lives2 !== 2'd2) begin errors++; $display("FAIL hit_goal_respawn: got goal=%b dead=%b up=%0d lives=%0d expected 0,0,345,2", goal2, dead2, up2, lives2); end
`else
    checks++; if (dead2 !== 1'b1 || goal2 !== 1'b0 || up2 !== 10'd66) begin errors++; $display("FAIL hit_goal: got dead=%b goal=%b up=%0d expected 1,0,66", dead2, goal2, up2); end
`endif
    hit = 1'b0;
    tick(1);
  endtask
  task automatic test_lives();
    enter_play();
`ifdef LIVES_EN
    checks++; if (lives1 !== 2'd3) begin errors++; $display("FAIL lives_reload: got %0d expected 3", lives1); end
    for (int i = 0; i < 3; i++) begin
      press(4'b0010);
      tick(6);
      hit = 1'b1;
      tick(1);
      hit = 1'b0;
      checks++; if (lives1 !== 2'(2 - i)) begin errors++; $display("FAIL lives_dec%0d: got %0d expected %0d", i, lives1, 2 - i); end
      checks++; if (dead1 !== (i == 2)) begin errors++; $display("FAIL lives_dead%0d: got %b expected %b", i, dead1, i == 2); end
      checks++; if (i < 2 && left1 !== 10'd200) begin errors++; $display("FAIL lives_respawn%0d: got %0d expected 200", i, left1); end
      tick(1);
    end
`else
    hit = 1'b1;
    tick(1);
    hit = 1'b0;
    checks++; if (lives1 !== 2'd1 || dead1 !== 1'b1) begin errors++; $display("FAIL lives_fixed: got lives=%0d dead=%b expected 1,1", lives1, dead1); end
    tick(1);
`endif
  endtask
  task automatic test_stage_abort();
    stage_state = 3'd3;
    tick(1);
    checks++; if (dead1 !== 1'b0 || dead2 !== 1'b0 || goal2 !== 1'b0) begin errors++; $display("FAIL idle_clear: got dead1=%b dead2=%b goal2=%b expected 0,0,0", dead1, dead2, goal2); end
    stage_state = 3'd5;
    tick(1);
    press(4'b1000);
    tick(10);
    stage_state = 3'd3;
    tick(1);
    checks++; if (up1 !== 10'd335 || left1 !== 10'd200 || mv1 !== 1'b0) begin errors++; $display("FAIL abort_idle: got %0d,%0d mv=%b expected 335,200,0", up1, left1, mv1); end
    stage_state = 3'd5;
    tick(1);
    press(4'b0010);
    checks++; if (mv1 !== 1'b1) begin errors++; $display("FAIL abort_rearm: got mv=%b expected 1", mv1); end
    tick(80);
    checks++; if (left1 !== 10'd180 || up1 !== 10'd335 || mv1 !== 1'b0) begin errors++; $display("FAIL abort_glide: got %0d,%0d mv=%b expected 335,180,0", up1, left1, mv1); end
  endtask
  initial begin
    test_reset();
    test_glide();
    test_bounds();
    test_goal();
    test_hit();
    test_lives();
    test_stage_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
